// File: rtl/move_cmd_seq.sv
// Command sequencer: replays a preloaded list of 16-bit Knight commands over the
// snd_cmd/cmd_snt/resp_rdy/resp handshake, with response timeout and bounded retry.
// Optional build macro SEQ_LOOP_EN adds a loop_i input for continuous replay.
module move_cmd_seq #(
  parameter int          DEPTH        = 8,
  parameter int          TIMEOUT_CLKS = 2000000,
  parameter int          MAX_RETRY    = 2,
  parameter logic [7:0]  ACK_VAL      = 8'hA5,
  localparam int         AW           = $clog2(DEPTH),
  localparam int         CW           = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [15:0]   load_data_i,
  input  logic          clr_i,
  input  logic          start_i,
  input  logic          abort_i,
`ifdef SEQ_LOOP_EN
  input  logic          loop_i,
`endif
  output logic [15:0]   cmd_o,
  output logic          snd_cmd_o,
  input  logic          cmd_snt_i,
  input  logic          resp_rdy_i,
  input  logic [7:0]    resp_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [CW-1:0] num_loaded_o,
  output logic [CW-1:0] num_done_o,
  output logic          full_o
);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, ndone_q, ndone_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          snd_q, snd_d, done_q, done_d, err_q, err_d;
  logic [1:0]    ec_q, ec_d;
  logic          ld_ok, go, last;

  assign busy_o = (state_q == SEND) || (state_q == WAIT_SNT) || (state_q == WAIT_RESP);
  assign full_o = (wr_ptr_q == CW'(DEPTH));
  assign ld_ok  = load_i && !full_o && !busy_o;
  assign go     = (state_q == IDLE) && start_i && (wr_ptr_q != '0);
  assign last   = ({1'b0, rd_ptr_q} == wr_ptr_q - CW'(1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ndone_d  = ndone_q;
    rd_ptr_d = rd_ptr_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    cmd_d    = cmd_q;
    snd_d    = 1'b0;
`ifdef SEQ_LOOP_EN
    done_d   = 1'b0;
`else
    done_d   = done_q;
`endif
    err_d    = err_q;
    ec_d     = ec_q;
    if (ld_ok) wr_ptr_d = wr_ptr_q + CW'(1);
    if (abort_i && state_q != IDLE) begin
      // abort overrides any same-cycle ack, timeout or send
      state_d = IDLE;
      err_d   = 1'b1;
      ec_d    = 2'b11;
    end else begin
      if (clr_i && !busy_o && !go) begin
        wr_ptr_d = '0;
        ndone_d  = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ec_d     = 2'b00;
      end
      case (state_q)
        IDLE: if (go) begin
          state_d  = SEND;
          rd_ptr_d = '0;
          ndone_d  = '0;
          retry_d  = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          ec_d     = 2'b00;
        end
        SEND: begin
          cmd_d   = mem_q[rd_ptr_q];
          snd_d   = 1'b1;
          state_d = WAIT_SNT;
        end
        WAIT_SNT: if (cmd_snt_i) begin
          timer_d = '0;
          state_d = WAIT_RESP;
        end
        WAIT_RESP: begin
          timer_d = timer_q + TW'(1);
          if (resp_rdy_i) begin
            if (resp_i == ACK_VAL) begin
`ifdef SEQ_LOOP_EN
              if (ndone_q != '1) ndone_d = ndone_q + CW'(1);
`else
              ndone_d = ndone_q + CW'(1);
`endif
              retry_d = '0;
              if (last) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                state_d  = SEND;
              end
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
              ec_d    = 2'b10;
            end
          end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
            if (retry_q < 3'(MAX_RETRY)) begin
              retry_d = retry_q + 3'd1;
              state_d = SEND;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
              ec_d    = 2'b01;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
`ifdef SEQ_LOOP_EN
          if (loop_i) begin
            rd_ptr_d = '0;
            retry_d  = '0;
            state_d  = SEND;
          end
`endif
        end
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      ndone_q  <= '0;
      rd_ptr_q <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      cmd_q    <= '0;
      snd_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ec_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      ndone_q  <= ndone_d;
      rd_ptr_q <= rd_ptr_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cmd_q    <= cmd_d;
      snd_q    <= snd_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ec_q     <= ec_d;
    end
  end

  // buffer contents need no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (ld_ok) mem_q[wr_ptr_q[AW-1:0]] <= load_data_i;
  end

  assign cmd_o        = cmd_q;
  assign snd_cmd_o    = snd_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = ec_q;
  assign num_loaded_o = wr_ptr_q;
  assign num_done_o   = ndone_q;
endmodule

// File: tb/tb_move_cmd_seq.sv
// Directed bench for move_cmd_seq: scoreboard of expected commands plus a
// RemoteComm responder model that acknowledges from a queue of response bytes.
module tb_move_cmd_seq;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] CAL_GYRO = 16'h2000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_i = 0, clr_i = 0, start_i = 0, abort_i = 0;
  logic [15:0] load_data_i = '0;
  logic [15:0] cmd_o;
  logic snd_cmd_o, cmd_snt_i, resp_rdy_i, busy_o, done_o, err_o, full_o;
  logic [7:0] resp_i;
  logic [1:0] err_code_o;
  logic [CW-1:0] num_loaded_o, num_done_o;

  logic r_snt = 0, r_rdy = 0, m_rdy = 0;
  logic [7:0] r_resp = '0, m_resp = '0;
  assign cmd_snt_i  = r_snt;
  assign resp_rdy_i = r_rdy | m_rdy;
  assign resp_i     = m_rdy ? m_resp : r_resp;

  move_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .MAX_RETRY(2), .ACK_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .load_data_i(load_data_i), .clr_i(clr_i),
    .start_i(start_i), .abort_i(abort_i), .cmd_o(cmd_o), .snd_cmd_o(snd_cmd_o),
    .cmd_snt_i(cmd_snt_i), .resp_rdy_i(resp_rdy_i), .resp_i(resp_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .num_loaded_o(num_loaded_o),
    .num_done_o(num_done_o), .full_o(full_o));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, last_snd = -1, n_snd = 0;
  bit lat_chk = 0, gap_chk = 0, rsp_en = 1;
  int pend = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  resp_q[$];
  logic [15:0] mdl[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: every send strobe must match the next queued command
  always @(negedge clk) begin
    if (snd_cmd_o) begin
      n_snd++;
      if (exp_q.size() == 0) chk("unexpected_snd", 32'(cmd_o), 32'hDEAD);
      else chk("cmd", 32'(cmd_o), 32'(exp_q.pop_front()));
      if (lat_chk) begin
        chk("start_latency", 32'(cyc - start_cyc), 32'd2);
        lat_chk = 0;
      end
      if (gap_chk && last_snd >= 0) chk("retry_gap", 32'(cyc - last_snd), 32'(TMO + 2));
      last_snd = cyc;
    end
  end

  // RemoteComm model: cmd_snt one cycle after the strobe, response three cycles later
  always @(negedge clk) begin
    r_snt = 0;
    r_rdy = 0;
    if (!rst_n) pend = 0;
    else if (snd_cmd_o && rsp_en) begin
      r_snt = 1;
      pend  = 3;
    end else if (pend != 0) begin
      pend--;
      if (pend == 0 && resp_q.size() != 0) begin
        r_rdy  = 1;
        r_resp = resp_q.pop_front();
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] d);
    load_i = 1; load_data_i = d;
    if (mdl.size() < DEPTH) mdl.push_back(d);
    tick();
    load_i = 0;
  endtask

  task automatic do_clr();
    clr_i = 1; tick(); clr_i = 0;
    mdl.delete();
  endtask

  task automatic do_start();
    start_i = 1; start_cyc = cyc; lat_chk = 1;
    tick();
    start_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (busy_o && n < 2000) begin tick(); n++; end
    chk("idle_wait_timeout", 32'(busy_o), 32'd0);
  endtask

  initial begin
    tick(2);
    rst_n = 1;
    tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_flags", {snd_cmd_o, done_o, err_o, err_code_o, full_o}, 0);
    chk("rst_counts", {num_loaded_o, num_done_o, cmd_o}, 0);

    // 1: two commands acknowledged
    do_load(CAL_GYRO); do_load(16'h47F3);
    foreach (mdl[i]) exp_q.push_back(mdl[i]);
    resp_q.push_back(8'hA5); resp_q.push_back(8'hA5);
    do_start();
    wait_idle();
    chk("t1_done", 32'(done_o), 1);
    chk("t1_err", {err_o, err_code_o}, 0);
    chk("t1_num_done", 32'(num_done_o), 2);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);

    // 2: no response -> three sends TMO+2 apart, then timeout error
    do_clr();
    do_load(16'h1111);
    repeat (3) exp_q.push_back(16'h1111);
    last_snd = -1; gap_chk = 1;
    do_start();
    wait_idle();
    gap_chk = 0;
    chk("t2_err", {err_o, err_code_o}, 3'b101);
    chk("t2_num_done", 32'(num_done_o), 0);
    chk("t2_done", 32'(done_o), 0);
    chk("t2_sb_empty", 32'(exp_q.size()), 0);

    // 3: bad response on the second command
    do_clr();
    do_load(16'hA001); do_load(16'hA002); do_load(16'hA003);
    exp_q.push_back(16'hA001); exp_q.push_back(16'hA002);
    resp_q.push_back(8'hA5); resp_q.push_back(8'h5A);
    do_start();
    wait_idle();
    tick(8);
    chk("t3_err", {err_o, err_code_o}, 3'b110);
    chk("t3_num_done", 32'(num_done_o), 1);
    chk("t3_sb_empty", 32'(exp_q.size()), 0);

    // 4: overfill, then play back exactly DEPTH entries
    do_clr();
    for (int i = 0; i < DEPTH + 2; i++) do_load(16'hB000 + 16'(i));
    chk("t4_full", 32'(full_o), 1);
    chk("t4_num_loaded", 32'(num_loaded_o), DEPTH);
    foreach (mdl[i]) begin exp_q.push_back(mdl[i]); resp_q.push_back(8'hA5); end
    do_start();
    wait_idle();
    chk("t4_done", 32'(done_o), 1);
    chk("t4_num_done", 32'(num_done_o), DEPTH);
    chk("t4_sb_empty", 32'(exp_q.size()), 0);

    // 5: abort while waiting for cmd_snt, then clean replay
    do_clr();
    do_load(16'hC001); do_load(16'hC002);
    exp_q.push_back(16'hC001);
    rsp_en = 0;
    do_start();
    tick(2);
    chk("t5_busy_pre", 32'(busy_o), 1);
    abort_i = 1; tick(); abort_i = 0;
    chk("t5_abort", {busy_o, err_o, err_code_o}, 4'b0111);
    rsp_en = 1;
    foreach (mdl[i]) begin exp_q.push_back(mdl[i]); resp_q.push_back(8'hA5); end
    do_start();
    chk("t5_flags_cleared", {err_o, err_code_o, busy_o}, 4'b0001);
    wait_idle();
    chk("t5_replay", {done_o, err_o, err_code_o}, 4'b1000);
    chk("t5_num_done", 32'(num_done_o), 2);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);

    // 6: asynchronous reset while waiting for the response
    do_clr();
    do_load(16'hD001);
    exp_q.push_back(16'hD001);
    do_start();
    tick(4);
    chk("t6_busy_pre", 32'(busy_o), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_outs", {busy_o, snd_cmd_o, done_o, err_o, err_code_o, full_o}, 0);
    chk("t6_rst_counts", {num_loaded_o, num_done_o, cmd_o}, 0);
    tick(2);
    rst_n = 1;
    tick();
    m_rdy = 1; m_resp = 8'hA5; tick(); m_rdy = 0;
    tick(3);
    chk("t6_after_resp", {busy_o, done_o, err_o, num_done_o, num_loaded_o}, 0);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
